fp64_addsub_sched: RTL and testbench
====================================

FP64_ADDSUB_SCHED -- requirements
Module: fp64_addsub_sched

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum cycles spent waiting for adder ready before an abort.
REQ-002 The module SHALL have parameter QNAN, default 64'h7FF8_0000_0000_0000, giving the result returned on timeout.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  64  IEEE-754 double operands.
REQ-008 req0_sub / req1_sub  input  1  1 = A-B, 0 = A+B.
REQ-009 add_clr  output  1  reset pulse to the shared adder.
REQ-010 add_load  output  1  operand-load strobe to the shared adder.
REQ-011 add_en  output  1  adder enable.
REQ-012 add_sub  output  1  PlusOrMinus control to the adder.
REQ-013 add_a, add_b  output  64  registered operands to the adder.
REQ-014 add_sum  input  64  adder result.
REQ-015 add_ready  input  1  adder result valid.
REQ-016 resp_valid  output  1  result available.
REQ-017 resp_id  output  1  requester that owns the result.
REQ-018 resp_result  output  64  captured result.
REQ-019 resp_err  output  1  result produced by timeout abort.
REQ-020 resp_ready  input  1  consumer accepts the response.

Function
REQ-021 FSM states SHALL be IDLE, CLEAR, LOAD, WAIT, RESP; one operation in flight at a time.
REQ-022 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally for exactly that cycle, register its a/b/sub and id, go to CLEAR.
REQ-023 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-024 reqN_ready SHALL be 0 in every state except IDLE, and at most one reqN_ready SHALL be high in any cycle.
REQ-025 CLEAR: add_clr=1 for exactly one cycle, then LOAD.
REQ-026 LOAD: add_load=1 and add_en=1 for exactly one cycle, timeout counter cleared, then WAIT.
REQ-027 WAIT: add_en=1; counter increments each cycle; add_ready=1 captures add_sum into resp_result, resp_err=0, go to RESP.
REQ-028 WAIT timeout: counter reaching TIMEOUT_CYCLES-1 without add_ready SHALL capture QNAN, set resp_err=1, go to RESP; add_ready in the same cycle takes priority (normal result).
REQ-029 RESP: resp_valid=1 with resp_id/resp_result/resp_err stable until resp_ready=1; on that cycle return to IDLE (next grant no earlier than following cycle).
REQ-030 add_a/add_b/add_sub SHALL stay constant from CLEAR through WAIT.
REQ-031 Minimum latency, grant to resp_valid, SHALL be 4 cycles when add_ready arrives the first WAIT cycle.
REQ-032 Requester inputs changing after acceptance SHALL not affect the in-flight operation.

Reset
REQ-033 rst SHALL force IDLE, all req*_ready/add_*/resp_* outputs 0, counter 0, last-grant pointer =1 (so requester 0 wins first tie).
REQ-034 rst mid-operation SHALL abandon the operation with no response; rst overrides all other inputs.

Structure
REQ-035 State encoding enum, QNAN constant and default TIMEOUT_CYCLES SHALL live in shared package fp64_pkg.
REQ-036 One sub-module, rr_arbiter2 (2-way round-robin grant with pointer), is natural; the rest is a single FSM.

Verification
REQ-037 req0: 3FF0000000000000 + 4000000000000000, adder model ready after 3 cycles -> resp_id=0, resp_result=4008000000000000, resp_err=0.
REQ-038 req0 and req1 valid same cycle, repeated twice -> grant order 0,1,0,1; never both readies high.
REQ-039 Adder never raises add_ready, TIMEOUT_CYCLES=8 -> resp after 8 WAIT cycles, resp_result=7FF8000000000000, resp_err=1.
REQ-040 resp_ready held low 10 cycles -> resp_valid and data stable, no new req accepted, add_clr/add_load stay 0.
REQ-041 rst asserted during WAIT -> next cycle all outputs 0, IDLE; fresh req1 then served normally with req0 winning ties afterwards.
REQ-042 req1: 4008000000000000 - 3FF0000000000000 (sub=1) -> add_sub=1 during LOAD/WAIT, resp_result=4000000000000000.

Source files
------------

// File: rtl/fp64_pkg.sv
// Shared types and constants for the fp64 add/sub scheduler.
package fp64_pkg;
    localparam int          DEF_TIMEOUT_CYCLES = 64;
    localparam logic [63:0] FP64_QNAN          = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Operation latched at grant time.
    typedef struct packed {
        logic        sub;
        logic [63:0] a;
        logic [63:0] b;
    } op_t;

    // Response held for the consumer.
    typedef struct packed {
        logic        id;
        logic        err;
        logic [63:0] result;
    } resp_t;
endpackage

// File: rtl/fp64_addsub_sched_if.sv
// Requester, shared-adder and response signals of the fp64 add/sub scheduler.
interface fp64_addsub_sched_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_sub, req1_sub;
    logic        add_clr, add_load, add_en, add_sub;
    logic [63:0] add_a, add_b;
    logic [63:0] add_sum;
    logic        add_ready;
    logic        resp_valid, resp_id, resp_err;
    logic [63:0] resp_result;
    logic        resp_ready;

    // Scheduler side.
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_sub, req1_sub, add_sum, add_ready, resp_ready,
        output req0_ready, req1_ready, add_clr, add_load, add_en, add_sub,
               add_a, add_b, resp_valid, resp_id, resp_err, resp_result
    );

    // Environment side: requesters, adder and consumer.
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_sub, req1_sub, add_sum, add_ready, resp_ready,
        input  req0_ready, req1_ready, add_clr, add_load, add_en, add_sub,
               add_a, add_b, resp_valid, resp_id, resp_err, resp_result
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_gnt
);
    logic r_last;

    // On a tie grant the requester that did not win last; otherwise pass through.
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) o_gnt = r_last ? 2'b01 : 2'b10;
    end

    // Pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst)         r_last <= 1'b1;
        else if (i_take) r_last <= o_gnt[1];
    end
endmodule

// File: rtl/fp64_addsub_sched.sv
// Shares one fp64 adder between two requesters, one operation in flight,
// with a timeout abort that returns a quiet NaN.
module fp64_addsub_sched
    import fp64_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [63:0] QNAN           = FP64_QNAN
) (
    input  logic               clk,
    input  logic               rst,
    fp64_addsub_sched_if.slave bus
);
    localparam logic [31:0] LP_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e      r_state, w_state_nxt;
    op_t         r_op;
    resp_t       r_resp;
    logic [31:0] r_cnt;
    logic [1:0]  w_req, w_gnt;
    logic        w_take;

    assign w_req = {bus.req1_valid, bus.req0_valid};

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_req  (w_req),
        .i_take (w_take),
        .o_gnt  (w_gnt)
    );

    assign bus.add_a       = r_op.a;
    assign bus.add_b       = r_op.b;
    assign bus.add_sub     = r_op.sub;
    assign bus.resp_id     = r_resp.id;
    assign bus.resp_err    = r_resp.err;
    assign bus.resp_result = r_resp.result;

    // Next state and state-decoded strobes; reset masks everything, including ready.
    always_comb begin
        w_state_nxt    = r_state;
        w_take         = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.add_clr    = 1'b0;
        bus.add_load   = 1'b0;
        bus.add_en     = 1'b0;
        bus.resp_valid = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: if (|w_gnt) begin
                    w_take         = 1'b1;
                    bus.req0_ready = w_gnt[0];
                    bus.req1_ready = w_gnt[1];
                    w_state_nxt    = ST_CLEAR;
                end
                ST_CLEAR: begin
                    bus.add_clr = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    bus.add_load = 1'b1;
                    bus.add_en   = 1'b1;
                    w_state_nxt  = ST_WAIT;
                end
                ST_WAIT: begin
                    bus.add_en = 1'b1;
                    if (bus.add_ready || r_cnt == LP_TMO_LAST) w_state_nxt = ST_RESP;
                end
                ST_RESP: begin
                    bus.resp_valid = 1'b1;
                    if (bus.resp_ready) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register, operand capture at grant, timeout counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_resp  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: if (|w_gnt) begin
                    r_op.a    <= w_gnt[1] ? bus.req1_a   : bus.req0_a;
                    r_op.b    <= w_gnt[1] ? bus.req1_b   : bus.req0_b;
                    r_op.sub  <= w_gnt[1] ? bus.req1_sub : bus.req0_sub;
                    r_resp.id <= w_gnt[1];
                end
                ST_LOAD: r_cnt <= '0;
                ST_WAIT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (bus.add_ready) begin
                        r_resp.result <= bus.add_sum;
                        r_resp.err    <= 1'b0;
                    end else if (r_cnt == LP_TMO_LAST) begin
                        r_resp.result <= QNAN;
                        r_resp.err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp64_addsub_sched.sv
// Directed bench for fp64_addsub_sched with a behavioural adder stub.
module tb_fp64_addsub_sched;
    logic clk, rst;
    fp64_addsub_sched_if bus ();

    fp64_addsub_sched #(.TIMEOUT_CYCLES(8), .QNAN(64'h7FF8_0000_0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, viol = 0;

    // Adder stub: ready m_dly WAIT cycles after the load strobe, returns m_sum.
    bit          m_on  = 1'b1;
    int          m_dly = 1;
    int          m_cnt = 0;
    logic [63:0] m_sum = '0;
    always @(posedge clk) begin
        if (rst)                              m_cnt <= 0;
        else if (bus.add_load)                m_cnt <= 1;
        else if (bus.add_en && m_cnt != 0)    m_cnt <= m_cnt + 1;
    end
    assign bus.add_ready = m_on && bus.add_en && !bus.add_load && (m_cnt == m_dly);
    assign bus.add_sum   = m_sum;

    // Both readies must never be high together.
    always @(posedge clk) if (bus.req0_ready && bus.req1_ready) viol <= viol + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic        s_gid, s_clr, s_load, s_sub, s_wsub, s_rid, s_err;
    logic [63:0] s_a, s_b, s_res;
    int          s_lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_req(input bit id, input logic [63:0] a, input logic [63:0] b, input bit sub);
        if (id) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; end
        else    begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; end
    endtask

    // Wait for a grant, drop and scramble the winner's inputs, sample the
    // adder side, then wait for resp_valid. Call right after a negedge.
    task automatic serve();
        int n = 0;
        #1;
        while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("grant_seen", 64'(bus.req0_ready | bus.req1_ready), 64'd1);
        s_gid = bus.req1_ready;
        @(negedge clk); s_lat = 1; s_clr = bus.add_clr;
        if (s_gid) begin
            bus.req1_valid = 1'b0; bus.req1_a = ~bus.req1_a; bus.req1_b = ~bus.req1_b; bus.req1_sub = ~bus.req1_sub;
        end else begin
            bus.req0_valid = 1'b0; bus.req0_a = ~bus.req0_a; bus.req0_b = ~bus.req0_b; bus.req0_sub = ~bus.req0_sub;
        end
        @(negedge clk); s_lat = 2;
        s_load = bus.add_load & bus.add_en; s_a = bus.add_a; s_b = bus.add_b; s_sub = bus.add_sub;
        @(negedge clk); s_lat = 3; s_wsub = bus.add_sub;
        while (!bus.resp_valid && s_lat < 40) begin @(negedge clk); s_lat++; end
        chk("resp_seen", 64'(bus.resp_valid), 64'd1);
        s_rid = bus.resp_id; s_res = bus.resp_result; s_err = bus.resp_err;
    endtask

    initial begin
        int bad;
        logic [63:0] hold_res;
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
        bus.resp_ready = 1'b1;

        // Reset state, with requests pending that reset must mask.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctl", 64'({bus.req0_ready, bus.req1_ready, bus.add_clr, bus.add_load, bus.add_en,
                            bus.add_sub, bus.resp_valid, bus.resp_id, bus.resp_err}), 64'd0);
        chk("rst_data", bus.add_a | bus.add_b | bus.resp_result, 64'd0);
        rst = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);

        // 1.0 + 2.0 = 3.0, adder ready on the third WAIT cycle.
        m_dly = 3; m_sum = 64'h4008_0000_0000_0000;
        set_req(0, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 0);
        serve();
        chk("t1_gid", 64'(s_gid), 64'd0);
        chk("t1_clr", 64'(s_clr), 64'd1);
        chk("t1_load", 64'(s_load), 64'd1);
        chk("t1_add_a", s_a, 64'h3FF0_0000_0000_0000);
        chk("t1_add_b", s_b, 64'h4000_0000_0000_0000);
        chk("t1_add_sub", 64'(s_sub), 64'd0);
        chk("t1_lat", 64'(s_lat), 64'd6);
        chk("t1_rid", 64'(s_rid), 64'd0);
        chk("t1_res", s_res, 64'h4008_0000_0000_0000);
        chk("t1_err", 64'(s_err), 64'd0);
        @(negedge clk);
        chk("t1_resp_drop", 64'(bus.resp_valid), 64'd0);

        // 3.0 - 1.0 = 2.0 on requester 1, minimum latency.
        m_dly = 1; m_sum = 64'h4000_0000_0000_0000;
        set_req(1, 64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1);
        serve();
        chk("t2_gid", 64'(s_gid), 64'd1);
        chk("t2_load_sub", 64'(s_sub), 64'd1);
        chk("t2_wait_sub", 64'(s_wsub), 64'd1);
        chk("t2_add_a", s_a, 64'h4008_0000_0000_0000);
        chk("t2_add_b", s_b, 64'h3FF0_0000_0000_0000);
        chk("t2_lat", 64'(s_lat), 64'd4);
        chk("t2_rid", 64'(s_rid), 64'd1);
        chk("t2_res", s_res, 64'h4000_0000_0000_0000);
        @(negedge clk);

        // Two rounds of simultaneous requests: order 0,1,0,1.
        m_sum = 64'h0;
        for (int r = 0; r < 2; r++) begin
            set_req(0, 64'h1, 64'h2, 0);
            set_req(1, 64'h3, 64'h4, 0);
            serve();
            chk("rr_first", 64'(s_gid), 64'd0);
            chk("rr_first_rid", 64'(s_rid), 64'd0);
            @(negedge clk);
            serve();
            chk("rr_second", 64'(s_gid), 64'd1);
            chk("rr_second_rid", 64'(s_rid), 64'd1);
            @(negedge clk);
        end

        // Consumer stalls 10 cycles: response holds, nothing new starts.
        bus.resp_ready = 1'b0; m_sum = 64'h4000_0000_0000_0000;
        set_req(0, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 0);
        set_req(1, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 0);
        serve();
        chk("t4_gid", 64'(s_gid), 64'd0);
        hold_res = s_res;
        chk("t4_res", hold_res, 64'h4000_0000_0000_0000);
        bad = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (!bus.resp_valid || bus.resp_result !== hold_res || bus.resp_id || bus.resp_err ||
                bus.req0_ready || bus.req1_ready || bus.add_clr || bus.add_load) bad++;
        end
        chk("t4_hold_stable", 64'(bad), 64'd0);
        m_sum = 64'h4010_0000_0000_0000;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        serve();
        chk("t4_next_gid", 64'(s_gid), 64'd1);
        chk("t4_next_res", s_res, 64'h4010_0000_0000_0000);
        @(negedge clk);

        // Adder never answers: 8 WAIT cycles then quiet NaN with error.
        m_on = 1'b0;
        set_req(0, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 0);
        serve();
        chk("t5_lat", 64'(s_lat), 64'd11);
        chk("t5_res", s_res, 64'h7FF8_0000_0000_0000);
        chk("t5_err", 64'(s_err), 64'd1);
        @(negedge clk);

        // Reset in WAIT abandons the operation.
        m_on = 1'b1; m_dly = 5;
        set_req(0, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 0);
        @(negedge clk); bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_wait", 64'(bus.add_en & ~bus.add_load), 64'd1);
        rst = 1'b1; bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        @(negedge clk); #1;
        chk("t6_rst_ctl", 64'({bus.req0_ready, bus.req1_ready, bus.add_clr, bus.add_load, bus.add_en,
                               bus.add_sub, bus.resp_valid, bus.resp_id, bus.resp_err}), 64'd0);
        chk("t6_rst_data", bus.add_a | bus.add_b | bus.resp_result, 64'd0);
        @(negedge clk);
        rst = 1'b0; bus.req0_valid = 1'b0; m_dly = 2; m_sum = 64'h4010_0000_0000_0000;
        set_req(1, 64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 0);
        serve();
        chk("t6_gid", 64'(s_gid), 64'd1);
        chk("t6_res", s_res, 64'h4010_0000_0000_0000);
        chk("t6_err", 64'(s_err), 64'd0);
        @(negedge clk);
        set_req(0, 64'h1, 64'h2, 0);
        set_req(1, 64'h3, 64'h4, 0);
        serve();
        chk("t6_tie_gid", 64'(s_gid), 64'd0);
        @(negedge clk);

        chk("never_both_ready", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
